// File: rtl/gpio5_pkg.sv
// Shared GPIO5 start-strobe definitions: FSM encodings, default hold lengths, strobe polarity.
package gpio5_pkg;

  localparam int unsigned HOLD_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_REL    = 2'd3
  } gpio5_state_e;

  localparam logic [HOLD_W-1:0] HOLD_ONE           = 9'd1;
  localparam logic [HOLD_W-1:0] DEF_ASSERT_LENGTH  = 9'd200;
  localparam logic [HOLD_W-1:0] DEF_RELEASE_LENGTH = 9'd200;

  // Strobe line is active-low.
  localparam logic STROBE_ACTIVE = 1'b0;

endpackage

// File: rtl/gpio5_sync.sv
// Multi-flop synchroniser for the asynchronous start strobe; resets to the inactive (high) level.
module gpio5_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio5_start_rx.sv
// GPIO5 start-strobe receiver: qualifies the synced strobe and raises level/pulse/request/overrun/count.
// States: IDLE idle | ARM counting lows | ACTIVE start held | REL counting highs before release.
module gpio5_start_rx
  import gpio5_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES    = 2,
  parameter logic [HOLD_W-1:0] ASSERT_LENGTH  = DEF_ASSERT_LENGTH,
  parameter logic [HOLD_W-1:0] RELEASE_LENGTH = DEF_RELEASE_LENGTH,
  parameter int unsigned       CNT_W          = 16
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             i_start_str,
  input  logic             i_ack,
  input  logic             i_ovr_clr,
  output logic             o_start_lvl,
  output logic             o_start_pulse,
  output logic             o_start_req,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_start_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic str_s;
  logic str_act;

  gpio5_state_e      state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;
  logic              accept;

  logic             lvl_q, lvl_d;
  logic             pulse_q, pulse_d;
  logic             req_q, req_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  gpio5_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .iclk  (iclk),
    .irst_n(irst_n),
    .d_i   (i_start_str),
    .q_o   (str_s)
  );

  assign str_act  = (str_s == STROBE_ACTIVE);
  assign hold_inc = hold_q + HOLD_ONE;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
      req_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      req_q   <= req_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  // A length of 1 skips the counting state entirely.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (str_act) begin
          if (ASSERT_LENGTH == HOLD_ONE) begin
            state_d = ST_ACTIVE;
            hold_d  = '0;
            accept  = 1'b1;
          end else begin
            state_d = ST_ARM;
            hold_d  = HOLD_ONE;
          end
        end
      end
      ST_ARM: begin
        if (!str_act) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (hold_inc == ASSERT_LENGTH) begin
          state_d = ST_ACTIVE;
          hold_d  = '0;
          accept  = 1'b1;
        end else begin
          hold_d = hold_inc;
        end
      end
      ST_ACTIVE: begin
        if (!str_act) begin
          if (RELEASE_LENGTH == HOLD_ONE) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            state_d = ST_REL;
            hold_d  = HOLD_ONE;
          end
        end
      end
      ST_REL: begin
        if (str_act) begin
          state_d = ST_ACTIVE;
          hold_d  = '0;
        end else if (hold_inc == RELEASE_LENGTH) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // An accept always wins over a same-cycle ack or overrun clear.
  always_comb begin
    lvl_d   = (state_d == ST_ACTIVE) || (state_d == ST_REL);
    pulse_d = accept;
    req_d   = req_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      req_d = 1'b1;
      cnt_d = cnt_q + CNT_ONE;
    end else if (i_ack) begin
      req_d = 1'b0;
    end
    if (accept && req_q && !i_ack) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  assign o_start_lvl   = lvl_q;
  assign o_start_pulse = pulse_q;
  assign o_start_req   = req_q;
  assign o_overrun     = ovr_q;
  assign o_start_cnt   = cnt_q;

endmodule
